// File: rtl/lif_loader_pkg.sv
// rtl/lif_loader_pkg.sv - shared types and constants for the multi-channel LIF parameter loader
package lif_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX       = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_ADDR     = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    localparam logic [2:0] BYTE_ADDR = 3'd0;
    localparam logic [2:0] BYTE_WA   = 3'd1;
    localparam logic [2:0] BYTE_WB   = 3'd2;
    localparam logic [2:0] BYTE_LEAK = 3'd3;
    localparam logic [2:0] BYTE_TMIN = 3'd4;
    localparam logic [2:0] BYTE_TMAX = 3'd5;
    localparam logic [2:0] BYTE_CHK  = 3'd6;

    localparam int FRAME_BYTES = 7;

endpackage

// File: rtl/lif_serial_byte_rx.sv
// rtl/lif_serial_byte_rx.sv - MSB-first serial to byte shifter with bit counter
module lif_serial_byte_rx
    import lif_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       sample,
    input  logic       bit_in,
    output logic       byte_valid,
    output logic [7:0] byte_out
);

    logic [6:0] shift_q;
    logic [2:0] bit_cnt;

    // Shift in sampled bits; clear restarts the byte, keeping a bit sampled on the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shift_q <= sample ? {6'b0, bit_in} : 7'b0;
            bit_cnt <= sample ? 3'd1 : 3'd0;
        end else if (sample) begin
            shift_q <= {shift_q[5:0], bit_in};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // The eighth bit completes the byte combinationally so the top can store it on this edge
    assign byte_valid = sample && !clear && (bit_cnt == 3'd7);
    assign byte_out   = {shift_q, bit_in};

endmodule

// File: rtl/lif_param_loader_multi.sv
// rtl/lif_param_loader_multi.sv - framed serial parameter loader into a per-channel LIF bank
module lif_param_loader_multi
    import lif_loader_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter int         W_WIDTH      = 3,
    parameter int         LEAK_WIDTH   = 2,
    parameter int         THR_WIDTH    = 8,
    parameter logic [7:0] CHK_SEED     = 8'hA5,
    parameter int         DEF_W        = 3,
    parameter int         DEF_LEAK     = 1,
    parameter int         DEF_THR_MIN  = 25,
    parameter int         DEF_THR_MAX  = 85,
    parameter int         THR_MIN_LO   = 10,
    parameter int         THR_MIN_HI   = 100,
    parameter int         THR_MAX_HI   = 200,
    parameter int         THR_MARGIN   = 10,
    parameter int         THR_FALLBACK = 30
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            serial_data_in,
    input  logic                            load_enable,
    output logic [NUM_CH*W_WIDTH-1:0]       weight_a_flat,
    output logic [NUM_CH*W_WIDTH-1:0]       weight_b_flat,
    output logic [NUM_CH*LEAK_WIDTH-1:0]    leak_flat,
    output logic [NUM_CH*THR_WIDTH-1:0]     thr_min_flat,
    output logic [NUM_CH*THR_WIDTH-1:0]     thr_max_flat,
    output logic [NUM_CH-1:0]               params_ready,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            frame_error,
    output logic [1:0]                      err_code
);

    localparam logic [8:0] THR_ONES9   = 9'((1 << THR_WIDTH) - 1);
    localparam logic [8:0] THR_MAX_CAP = (THR_MAX_HI > ((1 << THR_WIDTH) - 1)) ? THR_ONES9 : 9'(THR_MAX_HI);
    localparam logic [8:0] THR_LO9     = 9'(THR_MIN_LO);
    localparam logic [8:0] THR_HI9     = 9'(THR_MIN_HI);

    state_t     state, state_n;
    logic       le_prev, le_rise;
    logic       sample, start, abort, do_commit;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic [2:0] byte_idx;
    logic [7:0] stg_addr, stg_wa, stg_wb, stg_leak, stg_tmin, stg_tmax, stg_chk;

    logic [W_WIDTH-1:0]    wa_q   [NUM_CH];
    logic [W_WIDTH-1:0]    wb_q   [NUM_CH];
    logic [LEAK_WIDTH-1:0] leak_q [NUM_CH];
    logic [THR_WIDTH-1:0]  tmin_q [NUM_CH];
    logic [THR_WIDTH-1:0]  tmax_q [NUM_CH];
    logic [NUM_CH-1:0]     ready_q;

    assign le_rise = load_enable && !le_prev;
    assign start   = (state == ST_IDLE) && enable && le_rise;
    assign abort   = (state == ST_RX) && enable && !load_enable;
    assign sample  = start || ((state == ST_RX) && enable && load_enable);
    assign busy    = (state == ST_RX) || (state == ST_COMMIT);

    lif_serial_byte_rx u_byte_rx (
        .clk        (clk),
        .reset      (reset),
        .clear      (start || abort),
        .sample     (sample),
        .bit_in     (serial_data_in),
        .byte_valid (byte_valid),
        .byte_out   (byte_out)
    );

    // Field validation of the staged frame, consumed only in the COMMIT cycle
    logic [W_WIDTH-1:0]   wa_fix, wb_fix;
    logic [THR_WIDTH-1:0] tmin_f, tmax_f, tmin_fin, tmax_fin;
    logic [8:0]           tmin9, tmax9, fb_sum;
    logic                 tmax_ok, addr_bad, chk_ok;

    assign wa_fix   = (stg_wa[W_WIDTH-1:0] == '0) ? W_WIDTH'(1) : stg_wa[W_WIDTH-1:0];
    assign wb_fix   = (stg_wb[W_WIDTH-1:0] == '0) ? W_WIDTH'(1) : stg_wb[W_WIDTH-1:0];
    assign tmin_f   = stg_tmin[THR_WIDTH-1:0];
    assign tmax_f   = stg_tmax[THR_WIDTH-1:0];
    assign tmin_fin = ((9'(tmin_f) >= THR_LO9) && (9'(tmin_f) <= THR_HI9)) ? tmin_f : THR_WIDTH'(DEF_THR_MIN);
    assign tmin9    = 9'(tmin_fin);
    assign tmax9    = 9'(tmax_f);
    assign tmax_ok  = (tmax9 > (tmin9 + 9'(THR_MARGIN))) && (tmax9 <= THR_MAX_CAP);
    assign fb_sum   = tmin9 + 9'(THR_FALLBACK);
    assign tmax_fin = tmax_ok ? tmax_f : ((fb_sum > THR_ONES9) ? {THR_WIDTH{1'b1}} : fb_sum[THR_WIDTH-1:0]);
    assign addr_bad = stg_addr >= 8'(NUM_CH);
    assign chk_ok   = stg_chk == (CHK_SEED ^ stg_addr ^ stg_wa ^ stg_wb ^ stg_leak ^ stg_tmin ^ stg_tmax);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; enable low holds RX and COMMIT in place
    always_comb begin
        state_n   = state;
        do_commit = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_RX;
            ST_RX: begin
                if (abort) state_n = ST_IDLE;
                else if (byte_valid && (byte_idx == BYTE_CHK)) state_n = ST_COMMIT;
            end
            ST_COMMIT: if (enable) begin
                do_commit = 1'b1;
                state_n   = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: if (!load_enable) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Byte staging, status pulses and atomic bank commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            le_prev     <= 1'b0;
            byte_idx    <= '0;
            stg_addr    <= '0;
            stg_wa      <= '0;
            stg_wb      <= '0;
            stg_leak    <= '0;
            stg_tmin    <= '0;
            stg_tmax    <= '0;
            stg_chk     <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            err_code    <= ERR_NONE;
            ready_q     <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                wa_q[i]   <= W_WIDTH'(DEF_W);
                wb_q[i]   <= W_WIDTH'(DEF_W);
                leak_q[i] <= LEAK_WIDTH'(DEF_LEAK);
                tmin_q[i] <= THR_WIDTH'(DEF_THR_MIN);
                tmax_q[i] <= THR_WIDTH'(DEF_THR_MAX);
            end
        end else begin
            le_prev     <= load_enable;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (start) begin
                byte_idx <= '0;
                err_code <= ERR_NONE;
            end
            if (abort) begin
                byte_idx    <= '0;
                frame_error <= 1'b1;
                err_code    <= ERR_ABORT;
            end
            if (byte_valid) begin
                byte_idx <= byte_idx + 3'd1;
                case (byte_idx)
                    BYTE_ADDR: stg_addr <= byte_out;
                    BYTE_WA:   stg_wa   <= byte_out;
                    BYTE_WB:   stg_wb   <= byte_out;
                    BYTE_LEAK: stg_leak <= byte_out;
                    BYTE_TMIN: stg_tmin <= byte_out;
                    BYTE_TMAX: stg_tmax <= byte_out;
                    default:   stg_chk  <= byte_out;
                endcase
            end
            if (do_commit) begin
                if (addr_bad) begin
                    frame_error <= 1'b1;
                    err_code    <= ERR_ADDR;
                end else if (!chk_ok) begin
                    frame_error <= 1'b1;
                    err_code    <= ERR_CHECKSUM;
                end else begin
                    frame_done <= 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (stg_addr == 8'(i)) begin
                            wa_q[i]    <= wa_fix;
                            wb_q[i]    <= wb_fix;
                            leak_q[i]  <= stg_leak[LEAK_WIDTH-1:0];
                            tmin_q[i]  <= tmin_fin;
                            tmax_q[i]  <= tmax_fin;
                            ready_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign params_ready = ready_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign weight_a_flat[g*W_WIDTH +: W_WIDTH]      = wa_q[g];
        assign weight_b_flat[g*W_WIDTH +: W_WIDTH]      = wb_q[g];
        assign leak_flat[g*LEAK_WIDTH +: LEAK_WIDTH]    = leak_q[g];
        assign thr_min_flat[g*THR_WIDTH +: THR_WIDTH]   = tmin_q[g];
        assign thr_max_flat[g*THR_WIDTH +: THR_WIDTH]   = tmax_q[g];
    end

endmodule

// File: tb/tb_lif_param_loader_multi.sv
// tb/tb_lif_param_loader_multi.sv - directed self-checking bench for lif_param_loader_multi
module tb_lif_param_loader_multi;

    logic        clk = 1'b0;
    logic        reset, enable, serial_data_in, load_enable;
    logic [11:0] weight_a_flat, weight_b_flat;
    logic [7:0]  leak_flat;
    logic [31:0] thr_min_flat, thr_max_flat;
    logic [3:0]  params_ready;
    logic        busy, frame_done, frame_error;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lif_param_loader_multi dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .serial_data_in (serial_data_in),
        .load_enable    (load_enable),
        .weight_a_flat  (weight_a_flat),
        .weight_b_flat  (weight_b_flat),
        .leak_flat      (leak_flat),
        .thr_min_flat   (thr_min_flat),
        .thr_max_flat   (thr_max_flat),
        .params_ready   (params_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_error    (frame_error),
        .err_code       (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input int wa, input int wb,
                          input int lk, input int tmin, input int tmax);
        chk({tag, " wa"},   32'(weight_a_flat[ch*3 +: 3]), wa);
        chk({tag, " wb"},   32'(weight_b_flat[ch*3 +: 3]), wb);
        chk({tag, " leak"}, 32'(leak_flat[ch*2 +: 2]),     lk);
        chk({tag, " tmin"}, 32'(thr_min_flat[ch*8 +: 8]),  tmin);
        chk({tag, " tmax"}, 32'(thr_max_flat[ch*8 +: 8]),  tmax);
    endtask

    // Drives nbits bits MSB first; at hold_at, enable drops for 3 cycles with a corrupted data bit
    task automatic send_bits(input logic [55:0] f, input int nbits, input int hold_at);
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == hold_at) begin
                enable         = 1'b0;
                load_enable    = 1'b1;
                serial_data_in = ~f[55-i];
                repeat (3) @(negedge clk);
                enable = 1'b1;
            end
            load_enable    = 1'b1;
            serial_data_in = f[55-i];
            @(negedge clk);
        end
    endtask

    // Lets COMMIT happen; returns at the negedge where the result pulse is visible
    task automatic full_frame(input logic [55:0] f, input int hold_at);
        send_bits(f, 56, hold_at);
        chk("busy in commit", 32'(busy), 1);
        @(negedge clk);
    endtask

    task automatic end_frame();
        load_enable    = 1'b0;
        serial_data_in = 1'b0;
        @(negedge clk);
        chk("pulses cleared", {30'd0, frame_done, frame_error}, 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; load_enable = 1'b0; serial_data_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        for (int c = 0; c < 4; c++) chk_ch("reset", c, 3, 3, 1, 25, 85);
        chk("reset ready", 32'(params_ready), 4'b1111);
        chk("reset err", 32'(err_code), 0);
        chk("reset busy", 32'(busy), 0);

        // Valid frame to ch2, zero weight_b fixed to 1
        full_frame({8'h02, 8'h05, 8'h00, 8'h02, 8'h1E, 8'h64, 8'hDA}, -1);
        chk("f1 done", 32'(frame_done), 1);
        chk("f1 error", 32'(frame_error), 0);
        chk("f1 busy", 32'(busy), 0);
        chk_ch("f1 ch2", 2, 5, 1, 2, 30, 100);
        chk_ch("f1 ch0", 0, 3, 3, 1, 25, 85);
        chk_ch("f1 ch3", 3, 3, 3, 1, 25, 85);
        end_frame();

        // Bad checksum
        full_frame({8'h02, 8'h05, 8'h00, 8'h02, 8'h1E, 8'h64, 8'hDB}, -1);
        chk("chk error", 32'(frame_error), 1);
        chk("chk done", 32'(frame_done), 0);
        chk("chk code", 32'(err_code), 1);
        chk_ch("chk ch2", 2, 5, 1, 2, 30, 100);
        end_frame();
        chk("chk code sticky", 32'(err_code), 1);

        // Out-of-range address with a correct checksum
        full_frame({8'h07, 8'h01, 8'h01, 8'h01, 8'h1E, 8'h64, 8'hD9}, -1);
        chk("addr error", 32'(frame_error), 1);
        chk("addr code", 32'(err_code), 2);
        chk_ch("addr ch2", 2, 5, 1, 2, 30, 100);
        chk_ch("addr ch3", 3, 3, 3, 1, 25, 85);
        end_frame();

        // Threshold fallbacks on ch1: tmin 5 -> 25, tmax 20 -> 25+30
        full_frame({8'h01, 8'h02, 8'h03, 8'h00, 8'h05, 8'h14, 8'hB4}, -1);
        chk("thr done", 32'(frame_done), 1);
        chk("thr code", 32'(err_code), 0);
        chk_ch("thr ch1", 1, 2, 3, 0, 25, 55);
        end_frame();

        // Abort after 20 bits
        send_bits({8'h03, 8'h07, 8'h07, 8'h03, 8'h64, 8'hC8, 8'h09}, 20, -1);
        chk("abort busy before", 32'(busy), 1);
        load_enable = 1'b0;
        @(negedge clk);
        chk("abort error", 32'(frame_error), 1);
        chk("abort code", 32'(err_code), 3);
        chk("abort busy", 32'(busy), 0);
        chk_ch("abort ch3", 3, 3, 3, 1, 25, 85);
        chk_ch("abort ch1", 1, 2, 3, 0, 25, 55);
        @(negedge clk);

        // Valid frame to ch3 at the upper threshold bounds, with an enable freeze mid-frame
        full_frame({8'h03, 8'h07, 8'h07, 8'h03, 8'h64, 8'hC8, 8'h09}, 27);
        chk("bound done", 32'(frame_done), 1);
        chk("bound code", 32'(err_code), 0);
        chk_ch("bound ch3", 3, 7, 7, 3, 100, 200);
        end_frame();

        // Asynchronous reset after 30 bits
        send_bits({8'h00, 8'h01, 8'h01, 8'h01, 8'h1E, 8'h64, 8'hFF}, 30, -1);
        chk("midreset busy before", 32'(busy), 1);
        #1 reset = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 0);
        chk("midreset ready", 32'(params_ready), 4'b1111);
        chk("midreset err", 32'(err_code), 0);
        chk_ch("midreset ch2", 2, 3, 3, 1, 25, 85);
        chk_ch("midreset ch3", 3, 3, 3, 1, 25, 85);
        load_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_ch("after reset ch1", 1, 3, 3, 1, 25, 85);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
